// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   uart_state_t   - 2-bit FSM encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   DEF_CLK_CYCLES - default clock cycles per bit (100 MHz / 115200)
//   DEF_BIT_NUM    - default data bits per frame
//   CNT_W          - width of the per-bit cycle counter
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DEF_CLK_CYCLES = 868;
  localparam int DEF_BIT_NUM    = 8;
  localparam int CNT_W          = 16;

  // Half a bit period. Used to place the start-bit check at mid-bit so
  // that every later sample also lands mid-bit.
  function automatic logic [CNT_W-1:0] half_period_m1(input int clk_cycles);
    return CNT_W'(clk_cycles / 2 - 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   clk   - destination clock
//   rst_n - synchronous, active-low reset; both flops load RST_VAL
//   d     - asynchronous input
//   q     - synchronized output, two clk cycles behind d
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_reg <= RST_VAL;
      sync_reg <= RST_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver for 1 start bit, BIT_NUM data bits (LSB first)
// and 1 stop bit. Each bit is timed by a cycle counter and sampled at its
// mid-point.
//   i_clk       - system clock, rising edge
//   i_rst_n     - synchronous, active-low reset
//   i_rx_data   - asynchronous serial line, idle high
//   o_data      - last correctly framed word, held until the next good frame
//   o_valid     - one-cycle pulse, o_data updated in the same cycle
//   o_frame_err - one-cycle pulse when the stop bit is sampled low
//   o_busy      - high whenever the receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_CYCLES = DEF_CLK_CYCLES,
  parameter int BIT_NUM    = DEF_BIT_NUM
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_rx_data,
  output logic [BIT_NUM-1:0] o_data,
  output logic               o_valid,
  output logic               o_frame_err,
  output logic               o_busy
);

  localparam int              IDX_W   = $clog2(BIT_NUM + 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = half_period_m1(CLK_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BIT_NUM - 1);

  uart_state_t        state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [BIT_NUM-1:0] shift_reg;
  logic [BIT_NUM-1:0] data_reg;
  logic               valid_reg;
  logic               frame_err_reg;
  logic               busy_reg;
  logic               rx_s;
  logic               rx_q;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (i_rx_data),
    .q     (rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      busy_reg      <= 1'b0;
      rx_q          <= 1'b1;
    end else begin
      rx_q          <= rx_s;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          idx_reg <= '0;
          // Only a genuine 1->0 transition starts a frame, so a line that
          // stays low (break) cannot re-trigger.
          if (rx_q && !rx_s) begin
            state_reg <= START;
            busy_reg  <= 1'b1;
          end
        end

        START: begin
          if (cnt_reg == HALF_M1) begin
            cnt_reg <= '0;
            if (!rx_s) begin
              state_reg <= DATA;
            end else begin
              // Line back high at mid start bit: treat as a glitch.
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_reg == BIT_M1) begin
            cnt_reg   <= '0;
            // Right shift from the MSB: the first bit received ends at bit 0.
            shift_reg <= {rx_s, shift_reg[BIT_NUM-1:1]};
            idx_reg   <= idx_reg + IDX_W'(1);
            if (idx_reg == LAST_IDX) begin
              state_reg <= STOP;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt_reg == BIT_M1) begin
            cnt_reg <= '0;
            if (rx_s) begin
              data_reg  <= shift_reg;
              valid_reg <= 1'b1;
            end else begin
              frame_err_reg <= 1'b1;
            end
            // Leaving at mid stop bit leaves half a bit to catch the next
            // start edge of a back-to-back frame.
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          cnt_reg   <= '0;
          idx_reg   <= '0;
        end
      endcase
    end
  end

  assign o_data      = data_reg;
  assign o_valid     = valid_reg;
  assign o_frame_err = frame_err_reg;
  assign o_busy      = busy_reg;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with CLK_CYCLES=16, BIT_NUM=8.
// The serial line is driven by a transmitter-timed model, 16 cycles per bit.
module tb_uart_rx;

  localparam int CLKC = 16;
  localparam int BITS = 8;

  logic            clk;
  logic            rst_n;
  logic            rx;
  logic [BITS-1:0] o_data;
  logic            o_valid;
  logic            o_frame_err;
  logic            o_busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Monitor state
  int          cyc          = 0;
  int          valid_cnt    = 0;
  int          err_cnt      = 0;
  int          busy_cycles  = 0;
  int          busy_at_vld  = 0;
  int          overlap_cnt  = 0;
  int          valid_cyc_q[$];
  logic [7:0]  data_q[$];
  logic        prev_pulse   = 1'b0;

  uart_rx #(
    .CLK_CYCLES (CLKC),
    .BIT_NUM    (BITS)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx_data   (rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs observed on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid) begin
        valid_cnt = valid_cnt + 1;
        data_q.push_back(o_data);
        valid_cyc_q.push_back(cyc);
        if (o_busy) busy_at_vld = busy_at_vld + 1;
      end
      if (o_frame_err) err_cnt = err_cnt + 1;
      if (o_busy) busy_cycles = busy_cycles + 1;
      if ((o_valid && o_frame_err) || (prev_pulse && (o_valid || o_frame_err)))
        overlap_cnt = overlap_cnt + 1;
      prev_pulse = o_valid | o_frame_err;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  // All line-driving tasks start and end 1 time unit after a rising edge.
  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CLKC) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < BITS; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (o_data !== 8'h00) $display("FAIL reset_data: got %h want 00", o_data);
    else pass_cnt++;
    chk_cnt++;
    if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid);
    else pass_cnt++;
    chk_cnt++;
    if (o_frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", o_frame_err);
    else pass_cnt++;
    chk_cnt++;
    if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy);
    else pass_cnt++;
    @(posedge clk);
    #1;
    idle_cycles(10);
    $display("reset: outputs cleared");
  endtask

  task automatic test_single;
    int v0, e0, b0;
    v0 = valid_cnt; e0 = err_cnt; b0 = busy_at_vld;
    send_frame(8'hA5, 1'b1);
    idle_cycles(20);
    chk_cnt++;
    if (valid_cnt - v0 !== 1) $display("FAIL single_valid_count: got %0d want 1", valid_cnt - v0);
    else pass_cnt++;
    chk_cnt++;
    if (data_q[data_q.size()-1] !== 8'hA5) $display("FAIL single_data: got %h want a5", data_q[data_q.size()-1]);
    else pass_cnt++;
    chk_cnt++;
    if (err_cnt - e0 !== 0) $display("FAIL single_frame_err: got %0d want 0", err_cnt - e0);
    else pass_cnt++;
    chk_cnt++;
    if (busy_at_vld - b0 !== 0) $display("FAIL single_busy_at_valid: got %0d want 0", busy_at_vld - b0);
    else pass_cnt++;
    $display("single: frame a5 -> data %h", o_data);
  endtask

  task automatic test_back_to_back;
    int v0, n;
    v0 = valid_cnt;
    n  = data_q.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_cycles(20);
    chk_cnt++;
    if (valid_cnt - v0 !== 2) begin
      $display("FAIL b2b_valid_count: got %0d want 2", valid_cnt - v0);
    end else begin
      pass_cnt++;
      chk_cnt++;
      if (data_q[n] !== 8'h00) $display("FAIL b2b_first_data: got %h want 00", data_q[n]);
      else pass_cnt++;
      chk_cnt++;
      if (data_q[n+1] !== 8'hFF) $display("FAIL b2b_second_data: got %h want ff", data_q[n+1]);
      else pass_cnt++;
      chk_cnt++;
      if (valid_cyc_q[n+1] - valid_cyc_q[n] !== 160)
        $display("FAIL b2b_spacing: got %0d want 160", valid_cyc_q[n+1] - valid_cyc_q[n]);
      else pass_cnt++;
    end
    $display("back_to_back: frames 00 ff -> last data %h", o_data);
  endtask

  task automatic test_glitch;
    int v0, e0, b0;
    v0 = valid_cnt; e0 = err_cnt; b0 = busy_cycles;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle_cycles(30);
    chk_cnt++;
    if (busy_cycles - b0 !== 8) $display("FAIL glitch_busy_cycles: got %0d want 8", busy_cycles - b0);
    else pass_cnt++;
    chk_cnt++;
    if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0)
      $display("FAIL glitch_pulses: got valid %0d err %0d want 0 0", valid_cnt - v0, err_cnt - e0);
    else pass_cnt++;
    send_frame(8'h3C, 1'b1);
    idle_cycles(20);
    chk_cnt++;
    if (valid_cnt - v0 !== 1 || o_data !== 8'h3C)
      $display("FAIL glitch_followup: got valid %0d data %h want 1 3c", valid_cnt - v0, o_data);
    else pass_cnt++;
    $display("glitch: rejected, followup data %h", o_data);
  endtask

  task automatic test_frame_err;
    int v0, e0;
    send_frame(8'h11, 1'b1);
    idle_cycles(20);
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h3C, 1'b0);
    idle_cycles(40);
    chk_cnt++;
    if (err_cnt - e0 !== 1) $display("FAIL ferr_count: got %0d want 1", err_cnt - e0);
    else pass_cnt++;
    chk_cnt++;
    if (valid_cnt - v0 !== 0) $display("FAIL ferr_no_valid: got %0d want 0", valid_cnt - v0);
    else pass_cnt++;
    chk_cnt++;
    if (o_data !== 8'h11) $display("FAIL ferr_data_held: got %h want 11", o_data);
    else pass_cnt++;
    $display("frame_err: bad stop, data held %h", o_data);
  endtask

  task automatic test_break;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    idle_cycles(40);
    chk_cnt++;
    if (err_cnt - e0 !== 1) $display("FAIL break_err_count: got %0d want 1", err_cnt - e0);
    else pass_cnt++;
    send_frame(8'h5A, 1'b1);
    idle_cycles(20);
    chk_cnt++;
    if (valid_cnt - v0 !== 1 || o_data !== 8'h5A)
      $display("FAIL break_followup: got valid %0d data %h want 1 5a", valid_cnt - v0, o_data);
    else pass_cnt++;
    $display("break: one frame error, followup data %h", o_data);
  endtask

  task automatic test_reset_mid;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    // Start bit plus the first three data bits of 0x77 (1,1,1).
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    chk_cnt++;
    if (o_busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", o_busy);
    else pass_cnt++;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (o_data !== 8'h00 || o_valid !== 1'b0 || o_frame_err !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL rstmid_outputs: got data %h v %b e %b b %b want 00 0 0 0",
               o_data, o_valid, o_frame_err, o_busy);
    else pass_cnt++;
    @(posedge clk);
    #1;
    idle_cycles(200);
    chk_cnt++;
    if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0)
      $display("FAIL rstmid_no_pulse: got valid %0d err %0d want 0 0", valid_cnt - v0, err_cnt - e0);
    else pass_cnt++;
    send_frame(8'h81, 1'b1);
    idle_cycles(20);
    chk_cnt++;
    if (valid_cnt - v0 !== 1 || o_data !== 8'h81)
      $display("FAIL rstmid_followup: got valid %0d data %h want 1 81", valid_cnt - v0, o_data);
    else pass_cnt++;
    $display("reset_mid: aborted frame, followup data %h", o_data);
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_break();
    test_reset_mid();
    chk_cnt++;
    if (overlap_cnt !== 0) $display("FAIL pulse_exclusive: got %0d want 0", overlap_cnt);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's uart_tx.
- Recovers 8N1-style frames (1 start bit, BIT_NUM data bits LSB first, 1 stop bit) from an asynchronous serial line.
- Oversamples with a per-bit clock-cycle counter and samples each bit at mid-bit.
- Presents each received word with a one-cycle valid pulse; flags framing errors.

Parameters:
CLK_CYCLES, 868, i_clk cycles per bit period (100 MHz / 115200); legal range 4..65535 (16-bit counter)
BIT_NUM, 8, data bits per frame; legal range 5..9

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_rst_n  in  1  synchronous, active-low reset
i_rx_data  in  1  asynchronous serial line, idle high
o_data  out  BIT_NUM  last correctly framed word; held until the next good frame
o_valid  out  1  one-cycle pulse; o_data updated in the same cycle
o_frame_err  out  1  one-cycle pulse when the stop bit is sampled low
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - state=IDLE, counter=0, bit index=0, shift register=0.
  - o_data=0, o_valid=0, o_frame_err=0, o_busy=0.
  - Synchronizer flops and previous-sample flop reset to 1.
  - Reset mid-frame aborts the frame with no pulse.
- Input synchronization:
  - i_rx_data passes through a 2-flop synchronizer.
  - All decisions use the synchronized value rx_s, which is 2 cycles late.
  - A previous-sample flop (rx_q) provides edge detection.
- Constants: HALF = CLK_CYCLES/2 (integer division).
- State machine:
  - IDLE: counter=0, bit index=0. Start detection requires the falling edge rx_q=1 and rx_s=0. A line held low never re-triggers. On the edge, go to START.
  - START: increment the counter each cycle. When counter==HALF-1, sample rx_s:
    - 0 -> DATA, counter=0.
    - 1 -> IDLE (glitch reject, no pulse).
  - DATA: increment the counter. When counter==CLK_CYCLES-1:
    - Shift rx_s into the shift register MSB with a right shift, so bit 0 arrives first and ends at o_data[0].
    - counter=0, bit index+1.
    - After the BIT_NUM-th sample, go to STOP.
  - STOP: increment the counter. When counter==CLK_CYCLES-1, sample rx_s:
    - 1 -> o_data<=shift register, o_valid=1 for one cycle.
    - 0 -> o_frame_err=1 for one cycle; o_data unchanged.
    - In both cases go to IDLE with counter=0.
- Return to IDLE happens at the stop bit's mid-point, so a back-to-back start edge is never missed.
- o_valid and o_frame_err are mutually exclusive and never high for two consecutive cycles.
- Latency: from the rx_s falling edge (cycle E) to o_valid high = HALF + (BIT_NUM+1)*CLK_CYCLES + 1 cycles. Add 2 cycles to measure from the i_rx_data pin.
- Width rules:
  - Counter is 16 bits; compares use CLK_CYCLES-1 and HALF-1 at 16 bits.
  - Bit index is $clog2(BIT_NUM+1) bits.
- No flow control: a new o_valid overwrites o_data regardless of consumer state.

Decomposition:
- Shared package/header uart_pkg:
  - State encodings IDLE=0, START=1, DATA=2, STOP=3 (2-bit), shared with uart_tx.
  - Default CLK_CYCLES and BIT_NUM values.
- One natural sub-module: sync_2ff (parameterised reset value, here 1), reusable for other async inputs.
- Bit counter and FSM stay in uart_rx.

Test Plan:
(Bench uses CLK_CYCLES=16, BIT_NUM=8, driving i_rx_data with a uart_tx-timed model.)
1. Single frame 0xA5 -> exactly one o_valid pulse; o_data=0xA5; o_frame_err never high; o_busy falls in the valid cycle.
2. Back-to-back frames 0x00 then 0xFF, no idle gap -> two o_valid pulses 160 cycles apart; o_data=0x00 then 0xFF.
3. Glitch: line low for 4 cycles, then high -> o_busy high about 8 cycles; returns to IDLE; no o_valid or o_frame_err; a following 0x3C frame is received correctly.
4. Frame 0x3C with stop bit driven 0, after a prior good 0x11 -> one o_frame_err pulse; o_data stays 0x11; no o_valid.
5. Break: line held low for 400 cycles, then high, then frame 0x5A -> exactly one o_frame_err during the break; then o_valid with o_data=0x5A.
6. i_rst_n pulsed low for 1 cycle mid-DATA of frame 0x77 -> all outputs 0 next cycle; no pulse from the aborted frame; next full frame 0x81 gives o_data=0x81.
